// File: rtl/frame_pkg.sv
// Shared types and constants for the frame streamer: FSM state encoding,
// default image geometry and the widths/counts derived from it.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_IMG_WIDTH  = 256;
  localparam int DEF_IMG_HEIGHT = 256;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_CHANNELS   = 3;

  localparam int DEF_PIX_W   = DEF_CHANNELS * DEF_DEPTH;
  localparam int DEF_NUM_PIX = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int DEF_ADDR_W  = $clog2(DEF_NUM_PIX);

  // Counter width for n values; never below one bit so degenerate sizes still elaborate.
  function automatic int pos_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame buffer: simple dual-port RAM, one write port and one synchronous
// read port with one cycle of latency. Read data holds while re_i is low.
module frame_ram #(
  parameter int DATA_W      = 24,
  parameter int DEPTH_WORDS = 65536,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_streamer.sv
// Loads one frame into an on-chip buffer, then streams it out in raster order
// with sof/eol/eof flags and x/y position. FRAME_REPEAT_EN: start in DONE replays the stored frame.
module frame_streamer
  import frame_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CHANNELS   = DEF_CHANNELS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [CHANNELS*DEPTH-1:0]         in_pixel,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [CHANNELS*DEPTH-1:0]         out_pixel,
  input  logic                              out_ready,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              out_eof,
  output logic [pos_bits(IMG_WIDTH)-1:0]    posx,
  output logic [pos_bits(IMG_HEIGHT)-1:0]   posy,
  output logic                              busy,
  output logic                              done,
  output logic [1:0]                        dbg_state
);

  localparam int PIX_W   = CHANNELS * DEPTH;
  localparam int NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W  = pos_bits(NUM_PIX);
  localparam int X_W     = pos_bits(IMG_WIDTH);
  localparam int Y_W     = pos_bits(IMG_HEIGHT);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(IMG_HEIGHT - 1);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; the producer holds data stable from valid rising until that edge.

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [X_W-1:0]      rd_x_q, rd_x_d;
  logic [Y_W-1:0]      rd_y_q, rd_y_d;
  logic                rd_done_q, rd_done_d;
  logic                out_valid_q, out_valid_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;
  logic                eof_q, eof_d;
  logic [X_W-1:0]      posx_q, posx_d;
  logic [Y_W-1:0]      posy_q, posy_d;

  logic                ram_we;
  logic                ram_re;
  logic [PIX_W-1:0]    ram_rdata;

  frame_ram #(
    .DATA_W      (PIX_W),
    .DEPTH_WORDS (NUM_PIX),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (in_pixel),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      posx_q      <= '0;
      posy_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      rd_done_q   <= rd_done_d;
      out_valid_q <= out_valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      posx_q      <= posx_d;
      posy_q      <= posy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_x_d      = rd_x_q;
    rd_y_d      = rd_y_q;
    rd_done_d   = rd_done_q;
    out_valid_d = out_valid_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    posx_d      = posx_q;
    posy_d      = posy_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          wr_addr_d = '0;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          ram_we    = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = ST_STREAM;
            rd_addr_d = '0;
            rd_x_d    = '0;
            rd_y_d    = '0;
            rd_done_d = 1'b0;
          end
        end
      end

      ST_STREAM: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (eof_q) state_d = ST_DONE;
        end
        // The RAM read register doubles as the output stage, so a new read is
        // issued only when the current word is absent or leaving this cycle.
        if (!rd_done_q && (!out_valid_q || out_ready)) begin
          ram_re      = 1'b1;
          out_valid_d = 1'b1;
          sof_d       = (rd_addr_q == '0);
          eol_d       = (rd_x_q == LAST_X);
          eof_d       = (rd_addr_q == LAST_ADDR);
          posx_d      = rd_x_q;
          posy_d      = rd_y_q;
          if (rd_addr_q == LAST_ADDR) rd_done_d = 1'b1;
          else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (rd_x_q == LAST_X) begin
            rd_x_d = '0;
            rd_y_d = (rd_y_q == LAST_Y) ? '0 : rd_y_q + Y_W'(1);
          end else begin
            rd_x_d = rd_x_q + X_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (start) begin
`ifdef FRAME_REPEAT_EN
          state_d   = ST_STREAM;
          rd_addr_d = '0;
          rd_x_d    = '0;
          rd_y_d    = '0;
          rd_done_d = 1'b0;
`else
          state_d   = ST_LOAD;
          wr_addr_d = '0;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_STREAM);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  assign out_valid = out_valid_q;
  assign out_pixel = out_valid_q ? ram_rdata : '0;
  assign out_sof   = out_valid_q & sof_q;
  assign out_eol   = out_valid_q & eol_q;
  assign out_eof   = out_valid_q & eof_q;
  assign posx      = posx_q;
  assign posy      = posy_q;

endmodule
